// File: rtl/fmap_window_sequencer.sv
// fmap_window_sequencer: captures one MAP x MAP map of CH-channel words, then replays every K x K
// window (raster order, configurable stride) as a ready/valid beat stream.
// Latency: first beat 2 cycles after SCAN entry (1-cycle RAM read + output FIFO); 1 beat/cycle sustained.
// Backpressure: 2-entry output FIFO with read credit; at most 2 beats buffered, m_* held while stalled.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-low reset
//   s_valid/s_ready/s_data       producer word stream (ch0 in LSBs)
//   m_valid/m_ready/m_data       window beat stream
//   m_first/m_last/m_frame_last  beat position flags (window start, window end, frame end)
//   o_busy                       window beats still to issue or held
//   o_done                       one-cycle pulse after the frame-last beat is accepted
// Build option: FMAP_PING_PONG_EN doubles the RAM into two banks so filling overlaps scanning.

module fmap_ws_fifo #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic [1:0]   cnt_o
);
    // 2-entry FIFO, registered storage, head presented combinationally.
    // Latency: push visible at the output the next cycle.
    // Backpressure: caller must not push when full nor pop when empty.

    logic [W-1:0] mem_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_dat_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop_i) begin
                rptr_q <= ~rptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign vld_o = (cnt_q != 2'd0);
    assign dat_o = mem_q[rptr_q];
    assign cnt_o = cnt_q;
endmodule

module fmap_window_sequencer #(
    parameter int CH     = 3,
    parameter int DW     = 16,
    parameter int MAP    = 12,
    parameter int K      = 5,
    parameter int STRIDE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CH*DW-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CH*DW-1:0] m_data,
    output logic             m_first,
    output logic             m_last,
    output logic             m_frame_last,
    output logic             o_busy,
    output logic             o_done
);
    localparam int OUT   = (MAP - K) / STRIDE + 1;
    localparam int WORDS = MAP * MAP;
`ifdef FMAP_PING_PONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int W  = CH * DW;
    localparam int AW = ($clog2(WORDS) > 0) ? $clog2(WORDS) : 1;
    localparam int RW = ($clog2(NBANK * WORDS) > 0) ? $clog2(NBANK * WORDS) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;

    typedef enum logic {
        FILL = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic          issued_all_q, issued_all_d;
    logic          rd_vld_q, rd_first_q, rd_last_q, rd_flast_q;
    logic [W-1:0]  rd_dat_q;
    logic          s_ready_q, s_ready_d;
    logic          o_done_q;
`ifdef FMAP_PING_PONG_EN
    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic [1:0]    full_q, full_d;
`endif

    logic          wr_en, wr_last, rd_en, pop, credit_ok;
    logic          kx_max, ky_max, ox_max, oy_max;
    logic          first_now, last_now, flast_now;
    logic [RW-1:0] wr_addr, rd_addr;
    logic [2:0]    occ;
    logic          fifo_vld;
    logic [1:0]    fifo_cnt;
    logic [W+2:0]  fifo_dat;
    int            wr_base, rd_base;

    logic [W-1:0]  mem [NBANK * WORDS];

    always_comb begin
        wr_en     = s_valid && s_ready_q;
        wr_last   = wr_en && (wa_q == AW'(WORDS - 1));
        pop       = fifo_vld && m_ready;
        kx_max    = (kx_q == KW'(K - 1));
        ky_max    = (ky_q == KW'(K - 1));
        ox_max    = (ox_q == OW'(OUT - 1));
        oy_max    = (oy_q == OW'(OUT - 1));
        first_now = (kx_q == '0) && (ky_q == '0);
        last_now  = kx_max && ky_max;
        flast_now = last_now && ox_max && oy_max;

        // Credit counts FIFO occupancy plus the read in flight; a same-cycle pop frees
        // a slot so the stream keeps 1 beat/cycle with m_ready high.
        occ       = 3'(fifo_cnt) + 3'(rd_vld_q);
        credit_ok = pop ? (occ < 3'd3) : (occ < 3'd2);
        rd_en     = (state_q == SCAN) && !issued_all_q && credit_ok;

`ifdef FMAP_PING_PONG_EN
        wr_base = wbank_q ? WORDS : 0;
        rd_base = rbank_q ? WORDS : 0;
`else
        wr_base = 0;
        rd_base = 0;
`endif
        wr_addr = RW'(wr_base + int'(wa_q));
        rd_addr = RW'(rd_base + (int'(oy_q) * STRIDE + int'(ky_q)) * MAP
                              + int'(ox_q) * STRIDE + int'(kx_q));

        wa_d = wa_q;
        if (wr_en) begin
            wa_d = wr_last ? '0 : wa_q + AW'(1);
        end

        // kx innermost, then ky, ox, oy; all wrap so the next frame starts at zero.
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (rd_en) begin
            if (kx_max) begin
                kx_d = '0;
                if (ky_max) begin
                    ky_d = '0;
                    if (ox_max) begin
                        ox_d = '0;
                        oy_d = oy_max ? '0 : oy_q + OW'(1);
                    end else begin
                        ox_d = ox_q + OW'(1);
                    end
                end else begin
                    ky_d = ky_q + KW'(1);
                end
            end else begin
                kx_d = kx_q + KW'(1);
            end
        end

        state_d = state_q;
`ifdef FMAP_PING_PONG_EN
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        if (wr_last) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end
        case (state_q)
            FILL: if (full_q[rbank_q]) state_d = SCAN;
            SCAN: begin
                // The bank is free once its final read has launched; the
                // remaining beats already live in the read register / FIFO.
                if (rd_en && flast_now) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                    state_d         = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        s_ready_d = !full_d[wbank_d];
`else
        case (state_q)
            FILL:    if (wr_last) state_d = SCAN;
            SCAN:    if (pop && fifo_dat[W+2]) state_d = FILL;
            default: state_d = FILL;
        endcase
        s_ready_d = (state_d == FILL);
`endif
        issued_all_d = (state_d == SCAN) && (issued_all_q || (rd_en && flast_now));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= FILL;
            wa_q         <= '0;
            kx_q         <= '0;
            ky_q         <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            issued_all_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_flast_q   <= 1'b0;
            s_ready_q    <= 1'b0;
            o_done_q     <= 1'b0;
`ifdef FMAP_PING_PONG_EN
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            full_q       <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            wa_q         <= wa_d;
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            issued_all_q <= issued_all_d;
            rd_vld_q     <= rd_en;
            rd_first_q   <= first_now;
            rd_last_q    <= last_now;
            rd_flast_q   <= flast_now;
            s_ready_q    <= s_ready_d;
            o_done_q     <= pop && fifo_dat[W+2];
`ifdef FMAP_PING_PONG_EN
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            full_q       <= full_d;
`endif
        end
    end

    // Storage RAM: not reset, contents are only consumed after a full fill.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= s_data;
        end
        if (rd_en) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    fmap_ws_fifo #(.W(W + 3)) u_out_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .push_i     (rd_vld_q),
        .push_dat_i ({rd_flast_q, rd_last_q, rd_first_q, rd_dat_q}),
        .pop_i      (pop),
        .vld_o      (fifo_vld),
        .dat_o      (fifo_dat),
        .cnt_o      (fifo_cnt)
    );

    assign s_ready      = s_ready_q;
    assign m_valid      = fifo_vld;
    assign m_data       = fifo_dat[W-1:0];
    assign m_first      = fifo_dat[W];
    assign m_last       = fifo_dat[W+1];
    assign m_frame_last = fifo_dat[W+2];
    assign o_busy       = (state_q == SCAN) || fifo_vld || rd_vld_q;
    assign o_done       = o_done_q;
endmodule

// File: tb/tb_fmap_window_sequencer.sv
module tb_fmap_window_sequencer;
    localparam int W = 48;
`ifdef FMAP_PING_PONG_EN
    localparam int LAT = 4;
    localparam logic SRDY_SCAN = 1'b1;
`else
    localparam int LAT = 3;
    localparam logic SRDY_SCAN = 1'b0;
`endif

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic         i_rst = 1'b0;
    logic         sel = 1'b0;
    logic         drv_s_valid = 1'b0;
    logic         drv_m_ready = 1'b0;
    logic [W-1:0] drv_s_data = '0;

    logic         a_s_ready, a_m_valid, a_m_first, a_m_last, a_m_fl, a_busy, a_done;
    logic [W-1:0] a_m_data;
    logic         b_s_ready, b_m_valid, b_m_first, b_m_last, b_m_fl, b_busy, b_done;
    logic [W-1:0] b_m_data;

    fmap_window_sequencer dut_a (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_valid(drv_s_valid & ~sel), .s_ready(a_s_ready), .s_data(drv_s_data),
        .m_valid(a_m_valid), .m_ready(drv_m_ready & ~sel), .m_data(a_m_data),
        .m_first(a_m_first), .m_last(a_m_last), .m_frame_last(a_m_fl),
        .o_busy(a_busy), .o_done(a_done)
    );

    fmap_window_sequencer #(.K(4), .STRIDE(2)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_valid(drv_s_valid & sel), .s_ready(b_s_ready), .s_data(drv_s_data),
        .m_valid(b_m_valid), .m_ready(drv_m_ready & sel), .m_data(b_m_data),
        .m_first(b_m_first), .m_last(b_m_last), .m_frame_last(b_m_fl),
        .o_busy(b_busy), .o_done(b_done)
    );

    logic         obs_s_ready, obs_m_valid, obs_first, obs_last, obs_fl, obs_busy, obs_done;
    logic [W-1:0] obs_m_data;
    assign obs_s_ready = sel ? b_s_ready : a_s_ready;
    assign obs_m_valid = sel ? b_m_valid : a_m_valid;
    assign obs_m_data  = sel ? b_m_data  : a_m_data;
    assign obs_first   = sel ? b_m_first : a_m_first;
    assign obs_last    = sel ? b_m_last  : a_m_last;
    assign obs_fl      = sel ? b_m_fl    : a_m_fl;
    assign obs_busy    = sel ? b_busy    : a_busy;
    assign obs_done    = sel ? b_done    : a_done;

    int n_assert = 0;
    int n_fail = 0;
    int got [0:1599];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame f, word i carries {3{i + 1000*f}}.
    function automatic logic [W-1:0] word(input int idx);
        logic [15:0] v;
        v = 16'((idx % 144) + 1000 * (idx / 144));
        return {v, v, v};
    endfunction

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        drv_s_valid = 1'b0;
        drv_m_ready = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_s_ready", obs_s_ready, 0);
        chk("rst_m_valid", obs_m_valid, 0);
        chk("rst_m_data", obs_m_data, 0);
        chk("rst_flags", {obs_first, obs_last, obs_fl}, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_done", obs_done, 0);
        @(negedge i_clk);
        chk("rst_s_ready_rise", obs_s_ready, 1);
        chk("rst_no_beat", obs_m_valid, 0);
    endtask

    task automatic run(input int k, input int s, input int nfr, input int abort_at, input bit rnd);
        int outn, per, total, in_idx, beat, cyc, dones, ready_drops;
        int acc_c, first_c, last_c, fl_c, nf_c;
        int f, j, w, e, addr;
        bit prev_stall, prev_fl, fin, seen;
        logic [W-1:0] prev_dat;
        outn = (12 - k) / s + 1;
        per = outn * outn * k * k;
        total = nfr * per;
        in_idx = 0; beat = 0; cyc = 0; dones = 0; ready_drops = 0;
        acc_c = -1; first_c = -1; last_c = -1; fl_c = -1; nf_c = -1;
        prev_stall = 0; prev_fl = 0; fin = 0; seen = 0; prev_dat = '0;
        for (int i = 0; i < 1600; i++) got[i] = -1;
        while (!fin && cyc < 20000) begin
            @(posedge i_clk); #1;
            drv_s_valid = (in_idx < nfr * 144);
            drv_s_data  = word(in_idx);
            drv_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge i_clk);
            cyc++;
            if (prev_fl) begin
                chk("done_after_frame_last", obs_done, 1);
`ifndef FMAP_PING_PONG_EN
                chk("s_ready_at_done", obs_s_ready, 1);
`endif
            end
            if (obs_done) dones++;
            if (prev_stall) begin
                chk("valid_held_stall", obs_m_valid, 1);
                chk("data_held_stall", obs_m_data, prev_dat);
            end
            if (seen && beat < per && drv_s_valid && !obs_s_ready) ready_drops++;
            if (drv_s_valid && obs_s_ready) begin
                in_idx++;
                if (in_idx == 144) acc_c = cyc;
            end
            prev_fl = 0;
            if (obs_m_valid && drv_m_ready) begin
                f = beat / per;
                j = beat % per;
                w = j / (k * k);
                e = j % (k * k);
                addr = ((w / outn) * s + e / k) * 12 + (w % outn) * s + e % k;
                if (!seen) begin
                    seen = 1;
                    first_c = cyc;
                    chk("busy_in_scan", obs_busy, 1);
                    chk("s_ready_in_scan", obs_s_ready, SRDY_SCAN);
                end
                chk("beat_data", obs_m_data, word(f * 144 + addr));
                chk("beat_first", obs_first, e == 0);
                chk("beat_last", obs_last, e == k * k - 1);
                chk("beat_frame_last", obs_fl, j == per - 1);
                if (f == 0) got[j] = int'(obs_m_data[15:0]);
                if (j == per - 1) begin
                    prev_fl = 1;
                    if (f == 0) fl_c = cyc;
                end
                if (f == 1 && j == 0) nf_c = cyc;
                last_c = cyc;
                beat++;
                if (beat == abort_at) return;
            end
            prev_stall = obs_m_valid && !drv_m_ready;
            prev_dat = obs_m_data;
            if (beat == total && !prev_fl) fin = 1;
        end
        chk("beat_count", beat, total);
        chk("done_count", dones, nfr);
        chk("busy_idle_after", obs_busy, 0);
        if (!rnd) chk("first_beat_latency", first_c - acc_c, LAT);
        if (!rnd && nfr == 1) chk("no_bubble", last_c - first_c, total - 1);
        if (nfr == 2) begin
            chk("pp_gap_le_2", (nf_c - fl_c - 1) <= 2, 1);
            chk("pp_ready_held", ready_drops, 0);
        end
    endtask

    initial begin
        do_reset();

        // Default geometry, m_ready high.
        sel = 1'b0;
        run(5, 1, 1, 0, 1'b0);
        chk("w0_beat0", got[0], 0);
        chk("w0_beat4", got[4], 4);
        chk("w0_beat5", got[5], 12);
        chk("w0_last", got[24], 52);
        chk("w1_first", got[25], 1);
        chk("final_beat", got[1599], 143);

        // Random backpressure: identical sequence, stall stability.
        run(5, 1, 1, 0, 1'b1);
        chk("rnd_final_beat", got[1599], 143);

        // Reset mid-scan after 700 beats, then a fresh full frame.
        run(5, 1, 1, 700, 1'b0);
        do_reset();
        run(5, 1, 1, 0, 1'b0);
        chk("post_rst_beat0", got[0], 0);
        chk("post_rst_final", got[1599], 143);

        // K=4, STRIDE=2: OUT=5, 400 beats.
        sel = 1'b1;
        run(4, 2, 1, 0, 1'b0);
        chk("k4s2_w11_start", got[96], 26);
        chk("k4s2_w11_end", got[111], 65);
        chk("k4s2_final", got[399], 143);
        sel = 1'b0;

`ifdef FMAP_PING_PONG_EN
        // Two frames back to back, second frame offset by 1000.
        run(5, 1, 2, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
